// File: rtl/wb_sram_pkg.sv
// Shared types and sizing helpers for the Wishbone SRAM arbiter.
package wb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT,
    ACK
  } state_e;

  // Wide enough for RD_LATENCY up to 4 (counts RD_LATENCY-2 down to 0)
  localparam int CNT_W = 2;

  function automatic int gnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arb_select.sv
// Combinational priority picker: first request after the rotate pointer wins.
module wb_arb_select
  import wb_sram_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int GNT_W     = gnt_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [GNT_W-1:0]     i_rot,
  output logic [GNT_W-1:0]     o_gnt,
  output logic                 o_vld
);

  // Scan from lowest to highest priority so the highest set one lands last
  always_comb begin
    o_gnt = '0;
    o_vld = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (i_req[(int'(i_rot) + 1 + i) % NUM_PORTS]) begin
        o_gnt = GNT_W'((int'(i_rot) + 1 + i) % NUM_PORTS);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_sram_arbiter.sv
// Wishbone-classic arbiter/sequencer for a single-port byte-lane SRAM macro.
// Define WB_ARB_RR_EN for round-robin arbitration (fixed priority otherwise).
module wb_sram_arbiter
  import wb_sram_pkg::*;
#(
  parameter int NUM_PORTS  = 3,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          i_rst,
  input  logic [NUM_PORTS-1:0]          i_cyc,
  input  logic [NUM_PORTS-1:0]          i_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   i_adr,
  input  logic [NUM_PORTS*DATA_W-1:0]   i_dat,
  input  logic [NUM_PORTS*DATA_W/8-1:0] i_sel,
  output logic [NUM_PORTS-1:0]          o_ack,
  output logic [DATA_W-1:0]             o_rdt,
  output logic                          o_busy,
  output logic                          o_mem_en,
  output logic [ADDR_W-1:0]             o_mem_a,
  output logic [DATA_W/8-1:0]           o_mem_we,
  output logic [DATA_W-1:0]             o_mem_di,
  input  logic [DATA_W-1:0]             i_mem_do
);

  localparam int SW    = DATA_W / 8;
  localparam int GNT_W = gnt_w(NUM_PORTS);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GNT_W-1:0]     gnt_q, gnt_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;
  logic                 en_q, en_d;
  logic [SW-1:0]        we_q, we_d;
  logic [ADDR_W-1:0]    a_q, a_d;
  logic [DATA_W-1:0]    di_q, di_d;

  logic [GNT_W-1:0]     rot;
  logic [GNT_W-1:0]     sel_gnt;
  logic                 sel_vld;

  wb_arb_select #(
    .NUM_PORTS(NUM_PORTS),
    .GNT_W    (GNT_W)
  ) u_sel (
    .i_req(i_cyc),
    .i_rot(rot),
    .o_gnt(sel_gnt),
    .o_vld(sel_vld)
  );

`ifdef WB_ARB_RR_EN
  logic [GNT_W-1:0] ptr_q;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= GNT_W'(NUM_PORTS - 1);
    end else if (state_q == IDLE && sel_vld) begin
      ptr_q <= sel_gnt;
    end
  end

  assign rot = ptr_q;
`else
  assign rot = GNT_W'(NUM_PORTS - 1);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    en_d    = 1'b0;
    we_d    = '0;
    a_d     = a_q;
    di_d    = di_q;
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          gnt_d   = sel_gnt;
          en_d    = 1'b1;
          we_d    = i_sel[int'(sel_gnt)*SW +: SW] & {SW{i_we[sel_gnt]}};
          a_d     = i_adr[int'(sel_gnt)*ADDR_W +: ADDR_W];
          di_d    = i_dat[int'(sel_gnt)*DATA_W +: DATA_W];
          state_d = CMD;
        end
      end
      CMD: begin
        if (RD_LATENCY == 1) begin
          ack_d[gnt_q] = 1'b1;
          state_d      = ACK;
        end else begin
          cnt_d   = CNT_W'(RD_LATENCY - 2);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          ack_d[gnt_q] = 1'b1;
          state_d      = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // Never samples requests: the acked master is still dropping cyc
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      en_q    <= 1'b0;
      we_q    <= '0;
      a_q     <= '0;
      di_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      we_q    <= we_d;
      a_q     <= a_d;
      di_q    <= di_d;
    end
  end

  assign o_ack    = ack_q;
  assign o_rdt    = (|ack_q) ? i_mem_do : '0;
  assign o_busy   = (state_q != IDLE);
  assign o_mem_en = en_q;
  assign o_mem_we = we_q;
  assign o_mem_a  = a_q;
  assign o_mem_di = di_q;

endmodule
